// File: rtl/pattern_detect_ctrl_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// The reset configuration is the classic non-overlapping "two 1s" detector.
package pattern_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int   RST_PATTERN = 32'd3;
  localparam int   RST_LEN     = 32'd2;
  localparam logic RST_OVERLAP = 1'b0;
  localparam int   RST_TARGET  = 32'd1;

  // Width needed to hold a pattern length in the range 0..pat_w
  function automatic int calc_len_w(input int pat_w);
    return $clog2(pat_w + 32'd1);
  endfunction

endpackage

// File: rtl/pattern_detect_ctrl_if.sv
// Host control/status and serial bitstream bundle for pattern_detect_ctrl.
interface pattern_detect_ctrl_if
  import pattern_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = calc_len_w(PAT_W)
) ();

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             x_valid;
  logic             x;
  logic             z;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic             err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, x_valid, x,
    input  z, busy, done, match_cnt, err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, x_valid, x,
    output z, busy, done, match_cnt, err
  );

endinterface

// File: rtl/pattern_detect_ctrl_window_match.sv
// Bit history window with fill tracking; flags when the newest len bits,
// including the incoming bit, equal the low len bits of the pattern.
module pattern_window_match
  import pattern_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             x,
  output logic             hit
);

  logic [PAT_W-2:0] history_r;
  logic [LEN_W-1:0] fill_r;
  logic [PAT_W-1:0] cand_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W-1:0] len_m1_s;

  // Candidate window and masked compare against the pattern
  always_comb begin
    cand_s   = {history_r, x};
    len_m1_s = len - LEN_W'(1);
    mask_s   = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < int'(len));
    end
    hit = (fill_r >= len_m1_s) && (((cand_s ^ pattern) & mask_s) == {PAT_W{1'b0}});
  end

  // History shift and saturating fill count; clearing fill alone would do,
  // but clearing history too keeps stale bits out of debug views
  always_ff @(posedge clk) begin
    if (!rst) begin
      history_r <= {(PAT_W-1){1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (clr) begin
      history_r <= {(PAT_W-1){1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (shift_en) begin
      history_r <= cand_s[PAT_W-2:0];
      fill_r    <= (fill_r == LEN_W'(PAT_W)) ? fill_r : fill_r + LEN_W'(1);
    end else begin
      history_r <= history_r;
      fill_r    <= fill_r;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run controller for the programmable serial pattern detector: configuration
// registers, IDLE/RUN/DONE sequencing and the match counter.
module pattern_detect_ctrl
  import pattern_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = calc_len_w(PAT_W)
) (
  input logic                 clk,
  input logic                 rst,
  pattern_detect_ctrl_if.slave bus
);

  state_t           state_r;
  logic [PAT_W-1:0] pattern_r;
  logic [LEN_W-1:0] len_r;
  logic             overlap_r;
  logic [CNT_W-1:0] target_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic             cfg_open_s;
  logic [LEN_W-1:0] eff_len_s;
  logic [CNT_W-1:0] eff_target_s;
  logic             legal_s;
  logic             shift_en_s;
  logic             win_hit_s;
  logic             hit_s;
  logic             launch_s;
  logic             clr_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Legality uses a same-cycle config write so cfg_we+start launches with it
  always_comb begin
    cfg_open_s = (state_r == IDLE) || (state_r == DONE);
    if (cfg_open_s && bus.cfg_we) begin
      eff_len_s    = bus.cfg_len;
      eff_target_s = bus.cfg_target;
    end else begin
      eff_len_s    = len_r;
      eff_target_s = target_r;
    end
    legal_s    = (eff_len_s != {LEN_W{1'b0}}) && (eff_len_s <= LEN_W'(PAT_W)) &&
                 (eff_target_s != {CNT_W{1'b0}});
    shift_en_s = (state_r == RUN) && bus.x_valid && !bus.abort;
    hit_s      = shift_en_s && win_hit_s;
    launch_s   = cfg_open_s && bus.start && legal_s;
    clr_s      = launch_s || (hit_s && !overlap_r);
    cnt_inc_s  = match_cnt_r + CNT_W'(1);
  end

  pattern_window_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .clr      (clr_s),
    .len      (len_r),
    .pattern  (pattern_r),
    .x        (bus.x),
    .hit      (win_hit_s)
  );

  // Run FSM, configuration registers and match counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      pattern_r   <= PAT_W'(RST_PATTERN);
      len_r       <= LEN_W'(RST_LEN);
      overlap_r   <= RST_OVERLAP;
      target_r    <= CNT_W'(RST_TARGET);
      match_cnt_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.cfg_we) begin
            pattern_r <= bus.cfg_pattern;
            len_r     <= bus.cfg_len;
            overlap_r <= bus.cfg_overlap;
            target_r  <= bus.cfg_target;
          end
          if (bus.start) begin
            if (legal_s) begin
              err_r       <= 1'b0;
              done_r      <= 1'b0;
              match_cnt_r <= {CNT_W{1'b0}};
              busy_r      <= 1'b1;
              state_r     <= RUN;
            end else begin
              err_r   <= 1'b1;
              done_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (hit_s) begin
            match_cnt_r <= cnt_inc_s;
            // Ending here also guarantees the counter never wraps
            if (cnt_inc_s == target_r) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.z         = hit_s && rst;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.match_cnt = match_cnt_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Table-driven self-checking bench for pattern_detect_ctrl with an expectation queue.
module tb_pattern_detect_ctrl;
  import pattern_detect_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = calc_len_w(PAT_W);

  logic clk = 1'b0;
  logic rst;

  pattern_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  pattern_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_v;
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic [7:0] tgt;
    logic       start;
    logic       abort;
    logic       xv;
    logic       xb;
    logic       ez;
    logic       ebusy;
    logic       edone;
    logic [7:0] ecnt;
    logic       eerr;
  } step_t;

  step_t tbl[$];
  step_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    n        = 0;

  // ctl = {start, abort, x_valid, x}; ex = {z, busy, done, err}; cnt = match_cnt after the edge
  function automatic step_t mk(input logic r, input logic we, input logic [7:0] pat,
                               input logic [3:0] len, input logic ovl, input logic [7:0] tgt,
                               input logic [3:0] ctl, input logic [3:0] ex, input logic [7:0] cnt);
    step_t s;
    s.rst_v = r;      s.we    = we;     s.pat   = pat;    s.len  = len;
    s.ovl   = ovl;    s.tgt   = tgt;
    s.start = ctl[3]; s.abort = ctl[2]; s.xv    = ctl[1]; s.xb   = ctl[0];
    s.ez    = ex[3];  s.ebusy = ex[2];  s.edone = ex[1];  s.eerr = ex[0];
    s.ecnt  = cnt;
    return s;
  endfunction

  function automatic step_t st(input logic [3:0] ctl, input logic [3:0] ex, input logic [7:0] cnt);
    return mk(1'b1, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, ctl, ex, cnt);
  endfunction

  function automatic step_t cf(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                               input logic [7:0] tgt, input logic [3:0] ctl, input logic [3:0] ex,
                               input logic [7:0] cnt);
    return mk(1'b1, 1'b1, pat, len, ovl, tgt, ctl, ex, cnt);
  endfunction

  function automatic step_t rs(input logic [3:0] ctl, input logic [3:0] ex, input logic [7:0] cnt);
    return mk(1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 8'd0, ctl, ex, cnt);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  // Drive one cycle: z is checked mid-cycle, registered outputs just after the edge
  task automatic apply(input step_t s);
    step_t e;
    rst             = s.rst_v;
    bus.cfg_we      = s.we;
    bus.cfg_pattern = s.pat;
    bus.cfg_len     = s.len;
    bus.cfg_overlap = s.ovl;
    bus.cfg_target  = s.tgt;
    bus.start       = s.start;
    bus.abort       = s.abort;
    bus.x_valid     = s.xv;
    bus.x           = s.xb;
    exp_q.push_back(s);
    @(negedge clk);
    e = exp_q.pop_front();
    check("z", n, {7'd0, bus.z}, {7'd0, e.ez});
    @(posedge clk);
    #1;
    check("busy", n, {7'd0, bus.busy}, {7'd0, e.ebusy});
    check("done", n, {7'd0, bus.done}, {7'd0, e.edone});
    check("match_cnt", n, bus.match_cnt, e.ecnt);
    check("err", n, {7'd0, bus.err}, {7'd0, e.eerr});
    n++;
  endtask

  initial begin
    // Reset, then default "two 1s" detector on 0,1,1,1
    tbl.push_back(rs(4'b0000, 4'b0000, 8'd0));
    tbl.push_back(rs(4'b0000, 4'b0000, 8'd0));
    tbl.push_back(st(4'b1000, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b1010, 8'd1));
    tbl.push_back(st(4'b0011, 4'b0010, 8'd1));
    // Pattern 101, overlapping, target 3, written with start in the same cycle
    tbl.push_back(cf(8'h05, 4'd3, 1'b1, 8'd3, 4'b1000, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b1100, 8'd1));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd1));
    tbl.push_back(st(4'b0011, 4'b1100, 8'd2));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd2));
    tbl.push_back(st(4'b0011, 4'b1010, 8'd3));
    // Same stream non-overlapping: hits on bits 3 and 7 only, then abort
    tbl.push_back(cf(8'h05, 4'd3, 1'b0, 8'd3, 4'b1000, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b1100, 8'd1));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd1));
    tbl.push_back(st(4'b0011, 4'b0100, 8'd1));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd1));
    tbl.push_back(st(4'b0011, 4'b1100, 8'd2));
    tbl.push_back(st(4'b0100, 4'b0000, 8'd2));
    // Default config, invalid gaps carrying x=1 must not shift
    tbl.push_back(cf(8'h03, 4'd2, 1'b0, 8'd1, 4'b1000, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0010, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0001, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0001, 4'b0100, 8'd0));
    tbl.push_back(st(4'b0011, 4'b1010, 8'd1));

    bus.cfg_we = 1'b0; bus.cfg_pattern = 8'd0; bus.cfg_len = 4'd0; bus.cfg_overlap = 1'b0;
    bus.cfg_target = 8'd0; bus.start = 1'b0; bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Illegal len and target are rejected; cfg_we during RUN is ignored
    apply(cf(8'h03, 4'd0, 1'b0, 8'd1, 4'b1000, 4'b0001, 8'd1));
    apply(cf(8'h03, 4'd2, 1'b0, 8'd0, 4'b1000, 4'b0001, 8'd1));
    apply(cf(8'h03, 4'd2, 1'b0, 8'd1, 4'b1000, 4'b0100, 8'd0));
    apply(cf(8'h00, 4'd1, 1'b1, 8'd5, 4'b0000, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b1010, 8'd1));

    // Abort beats a completing bit; abort in IDLE does nothing
    apply(cf(8'h03, 4'd2, 1'b1, 8'd3, 4'b1000, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b1100, 8'd1));
    apply(st(4'b0111, 4'b0000, 8'd1));
    apply(st(4'b0100, 4'b0000, 8'd1));

    // Reset mid-run forces z low, clears status and restores default config
    apply(st(4'b1000, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b1100, 8'd1));
    apply(rs(4'b0011, 4'b0000, 8'd0));
    apply(st(4'b1000, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b0100, 8'd0));
    apply(st(4'b0011, 4'b1010, 8'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
- Run controller for a programmable serial bit-pattern detector, generalising the two-consecutive-1s Mealy detector.
- Holds the detector configuration: pattern, length, overlap mode and match target.
- Arms and disarms a detection run, feeds qualified bits through a pattern window and counts matches.
- Ends the run when the target count is reached; sits between a control host and a serial bitstream source.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter and target
LEN_W, $clog2(PAT_W+1), width of the length field

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
cfg_we  in  1  config write strobe
cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit
cfg_len  in  LEN_W  pattern length, legal 1..PAT_W
cfg_overlap  in  1  1 = overlapping matches, 0 = history cleared after match
cfg_target  in  CNT_W  matches that end the run, legal >=1
start  in  1  begin run
abort  in  1  cancel run
x_valid  in  1  qualifies x
x  in  1  serial data bit
z  out  1  Mealy match pulse, combinational, same cycle as the completing bit
busy  out  1  run in progress
done  out  1  target reached (level)
match_cnt  out  CNT_W  matches in current/last run
err  out  1  last start rejected for illegal config (sticky)

Behaviour:
- Reset (rst=0 at edge): state IDLE; busy=0, done=0, err=0, match_cnt=0, history and fill cleared. z forced 0 while rst=0.
- Reset config: pattern=...011, len=2, overlap=0, target=1, which is the classic non-overlapping "two 1s" detector.
- States: IDLE, RUN, DONE; encoded 2 bits, unused code -> IDLE.
- cfg_we: registers all cfg_* fields next edge, only in IDLE or DONE. Ignored in RUN.
- start in IDLE/DONE:
  - Illegal config (len=0, len>PAT_W or target=0): err<=1, state->IDLE, done<=0, match_cnt unchanged.
  - Legal config: err<=0, done<=0, match_cnt<=0, history and fill<=0, state->RUN, busy=1 from next cycle.
  - start in RUN: ignored.
- Same-cycle cfg_we+start in IDLE/DONE: the config check uses the newly written values; the run starts with them.
- RUN, per x_valid=1 cycle:
  - cand = {history[PAT_W-2:0], x}.
  - Hit = (fill >= len-1) and the low len bits of cand equal the low len bits of pattern.
  - z = hit, in the same cycle (0 latency).
  - Next edge: history<=cand; fill<=min(fill+1, PAT_W).
  - On hit: match_cnt+1. If overlap=0, fill<=0.
  - If match_cnt+1 == target: state->DONE, busy<=0, done<=1.
- x_valid=0: no shift, z=0.
- z=0 in IDLE and DONE regardless of x.
- abort in RUN: state->IDLE next edge, busy<=0, z=0 that cycle (abort beats a same-cycle hit), match_cnt held, done stays 0.
- abort outside RUN: no effect.
- match_cnt never wraps; the run terminates at target <= 2^CNT_W-1.
- DONE holds done=1 and match_cnt until start or reset.

Decomposition:
- Package pattern_detect_pkg: state enum (IDLE/RUN/DONE), reset config constants (pattern 'b11, len 2, overlap 0, target 1), LEN_W derivation helper.
- Sub-module pattern_window_match: history shift register, fill counter and masked compare. Inputs shift_en, clr, len, pattern, x; outputs hit. The controller FSM, config registers and counter stay in the top.

Test Plan:
1. Reset defaults, start, x_valid stream 0,1,1,1 -> z=1 only on the third bit; match_cnt=1; DONE next edge (done=1, busy=0); the fourth bit gives z=0.
2. Config pattern='b101, len=3, overlap=1, target=3; stream 1,0,1,0,1,0,1 -> z on bits 3, 5, 7; done after bit 7; match_cnt=3.
3. Same stream, overlap=0, target=3 -> z on bits 3 and 7 only; match_cnt=2; busy still 1.
4. Default config with x_valid=0 cycles between bits 1 and 1 carrying x=1 -> gaps produce no shift and no z; match occurs on the second valid 1.
5. start with cfg_len=0 -> err=1, busy=0, state IDLE. cfg_we in RUN -> config unchanged (check via a subsequent run).
6. abort in the same cycle as a completing bit -> z=0, IDLE, match_cnt held. Reset mid-run (rst=0 for one edge) -> all outputs 0 and defaults restored.
